rx_cmd_parser: RTL and testbench

RX_CMD_PARSER -- requirements
Module: rx_cmd_parser

---
 rtl/rx_cmd_parser.sv | 185 ++++++++++++++++++
 tb/tb_rx_cmd_parser.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/rx_cmd_parser.sv
// UART command parser: decodes write/read/ALU command byte streams into
// register-file and ALU pulses, and returns results over a TX byte handshake.
module rx_cmd_parser #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  input  logic [DATA_WIDTH-1:0]   RF_RD_DATA,
  input  logic                    RF_RD_DATA_VLD,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VLD,
  input  logic                    TX_BUSY,
  output logic [ADDR_WIDTH-1:0]   RF_ADDR,
  output logic [DATA_WIDTH-1:0]   RF_WR_DATA,
  output logic                    RF_WR_EN,
  output logic                    RF_RD_EN,
  output logic [3:0]              ALU_FUN,
  output logic                    ALU_EN,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD,
  output logic                    CMD_ERR
);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B,
    FUN, ALU_WAIT, TX_LO, TX_HI, TX_RD
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic [2*DATA_WIDTH-1:0] alu_res_q, alu_res_d;
  logic [3:0]              alu_fun_q, alu_fun_d;
  logic                    rf_wr_en_q, rf_wr_en_d;
  logic                    rf_rd_en_q, rf_rd_en_d;
  logic                    alu_en_q, alu_en_d;
  logic                    cmd_err_q, cmd_err_d;
  logic                    tx_vld_q, tx_vld_d;
  logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
  logic [DATA_WIDTH-1:0]   tx_byte;
  state_t                  tx_next;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wr_data_q  <= '0;
      rd_data_q  <= '0;
      alu_res_q  <= '0;
      alu_fun_q  <= '0;
      rf_wr_en_q <= 1'b0;
      rf_rd_en_q <= 1'b0;
      alu_en_q   <= 1'b0;
      cmd_err_q  <= 1'b0;
      tx_vld_q   <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wr_data_q  <= wr_data_d;
      rd_data_q  <= rd_data_d;
      alu_res_q  <= alu_res_d;
      alu_fun_q  <= alu_fun_d;
      rf_wr_en_q <= rf_wr_en_d;
      rf_rd_en_q <= rf_rd_en_d;
      alu_en_q   <= alu_en_d;
      cmd_err_q  <= cmd_err_d;
      tx_vld_q   <= tx_vld_d;
      tx_data_q  <= tx_data_d;
    end
  end

  // Byte and successor for whichever TX state is active.
  always_comb begin
    tx_byte = rd_data_q;
    tx_next = IDLE;
    if (state_q == TX_LO) begin
      tx_byte = alu_res_q[DATA_WIDTH-1:0];
      tx_next = TX_HI;
    end else if (state_q == TX_HI) begin
      tx_byte = alu_res_q[2*DATA_WIDTH-1:DATA_WIDTH];
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wr_data_d  = wr_data_q;
    rd_data_d  = rd_data_q;
    alu_res_d  = alu_res_q;
    alu_fun_d  = alu_fun_q;
    rf_wr_en_d = 1'b0;
    rf_rd_en_d = 1'b0;
    alu_en_d   = 1'b0;
    cmd_err_d  = 1'b0;
    tx_vld_d   = tx_vld_q;
    tx_data_d  = tx_data_q;
    unique case (state_q)
      IDLE: if (RX_D_VLD) begin
        case (RX_P_DATA)
          DATA_WIDTH'(8'hAA): state_d = WR_ADDR;
          DATA_WIDTH'(8'hBB): state_d = RD_ADDR;
          DATA_WIDTH'(8'hCC): state_d = OP_A;
          DATA_WIDTH'(8'hDD): state_d = FUN;
          default:            cmd_err_d = 1'b1;
        endcase
      end
      WR_ADDR: if (RX_D_VLD) begin
        addr_d  = ADDR_WIDTH'(RX_P_DATA);
        state_d = WR_DATA;
      end
      WR_DATA: if (RX_D_VLD) begin
        wr_data_d  = RX_P_DATA;
        rf_wr_en_d = 1'b1;
        state_d    = IDLE;
      end
      RD_ADDR: if (RX_D_VLD) begin
        addr_d     = ADDR_WIDTH'(RX_P_DATA);
        rf_rd_en_d = 1'b1;
        state_d    = RD_WAIT;
      end
      RD_WAIT: begin
        cmd_err_d = RX_D_VLD;
        if (RF_RD_DATA_VLD) begin
          rd_data_d = RF_RD_DATA;
          state_d   = TX_RD;
        end
      end
      OP_A: if (RX_D_VLD) begin
        addr_d     = '0;
        wr_data_d  = RX_P_DATA;
        rf_wr_en_d = 1'b1;
        state_d    = OP_B;
      end
      OP_B: if (RX_D_VLD) begin
        addr_d     = ADDR_WIDTH'(1);
        wr_data_d  = RX_P_DATA;
        rf_wr_en_d = 1'b1;
        state_d    = FUN;
      end
      FUN: if (RX_D_VLD) begin
        alu_fun_d = RX_P_DATA[3:0];
        alu_en_d  = 1'b1;
        state_d   = ALU_WAIT;
      end
      ALU_WAIT: begin
        cmd_err_d = RX_D_VLD;
        if (ALU_OUT_VLD) begin
          alu_res_d = ALU_OUT;
          state_d   = TX_LO;
        end
      end
      TX_LO, TX_HI, TX_RD: begin
        cmd_err_d = RX_D_VLD;
        // Present a byte only from a cycle with TX_D_VLD low and TX_BUSY low,
        // which guarantees an idle gap between consecutive bytes.
        if (tx_vld_q) begin
          if (!TX_BUSY) begin
            tx_vld_d = 1'b0;
            state_d  = tx_next;
          end
        end else if (!TX_BUSY) begin
          tx_vld_d  = 1'b1;
          tx_data_d = tx_byte;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign RF_ADDR    = addr_q;
  assign RF_WR_DATA = wr_data_q;
  assign RF_WR_EN   = rf_wr_en_q;
  assign RF_RD_EN   = rf_rd_en_q;
  assign ALU_FUN    = alu_fun_q;
  assign ALU_EN     = alu_en_q;
  assign TX_P_DATA  = tx_data_q;
  assign TX_D_VLD   = tx_vld_q;
  assign CMD_ERR    = cmd_err_q;

endmodule

// File: tb/tb_rx_cmd_parser.sv
// Directed bench for rx_cmd_parser: write, read, ALU and error command
// sequences with hand-computed expectations.
module tb_rx_cmd_parser;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  RX_P_DATA;
  logic        RX_D_VLD;
  logic [7:0]  RF_RD_DATA;
  logic        RF_RD_DATA_VLD;
  logic [15:0] ALU_OUT;
  logic        ALU_OUT_VLD;
  logic        TX_BUSY;
  logic [3:0]  RF_ADDR;
  logic [7:0]  RF_WR_DATA;
  logic        RF_WR_EN;
  logic        RF_RD_EN;
  logic [3:0]  ALU_FUN;
  logic        ALU_EN;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;
  logic        CMD_ERR;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned wr_cnt = 0, rd_cnt = 0, alu_cnt = 0, err_cnt = 0, overlap = 0;

  rx_cmd_parser #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .CLK(CLK), .RST(RST),
    .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RF_RD_DATA(RF_RD_DATA), .RF_RD_DATA_VLD(RF_RD_DATA_VLD),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD), .TX_BUSY(TX_BUSY),
    .RF_ADDR(RF_ADDR), .RF_WR_DATA(RF_WR_DATA), .RF_WR_EN(RF_WR_EN),
    .RF_RD_EN(RF_RD_EN), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .CMD_ERR(CMD_ERR)
  );

  always #5 CLK = ~CLK;

  // Pulse counters and mutual-exclusion watch over the whole run.
  always @(posedge CLK) begin
    if (RF_WR_EN === 1'b1) wr_cnt++;
    if (RF_RD_EN === 1'b1) rd_cnt++;
    if (ALU_EN   === 1'b1) alu_cnt++;
    if (CMD_ERR  === 1'b1) err_cnt++;
    if ($countones({RF_WR_EN, RF_RD_EN, ALU_EN}) > 1) overlap++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    tick();
    RX_D_VLD  = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_wr"},  RF_WR_EN, 0);
    check({tag, "_rd"},  RF_RD_EN, 0);
    check({tag, "_alu"}, ALU_EN,   0);
    check({tag, "_tx"},  TX_D_VLD, 0);
  endtask

  initial begin
    RST = 1'b1; RX_P_DATA = '0; RX_D_VLD = 1'b0; RF_RD_DATA = '0;
    RF_RD_DATA_VLD = 1'b0; ALU_OUT = '0; ALU_OUT_VLD = 1'b0; TX_BUSY = 1'b0;
    tick(); tick();
    check_quiet("rst");
    check("rst_err",  CMD_ERR, 0);
    check("rst_addr", RF_ADDR, 0);
    check("rst_wdat", RF_WR_DATA, 0);
    check("rst_fun",  ALU_FUN, 0);
    check("rst_txd",  TX_P_DATA, 0);
    RST = 1'b0;
    tick();

    // Write command
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
    check("wr_en",   RF_WR_EN, 1);
    check("wr_addr", RF_ADDR, 5);
    check("wr_data", RF_WR_DATA, 8'h3C);
    check("wr_rden", RF_RD_EN, 0);
    tick();
    check("wr_en_off", RF_WR_EN, 0);
    tick();

    // Read command, data returns 3 cycles after RF_RD_EN
    send_byte(8'hBB); send_byte(8'h02);
    check("rd_en",   RF_RD_EN, 1);
    check("rd_addr", RF_ADDR, 2);
    tick();
    check("rd_en_off", RF_RD_EN, 0);
    tick();
    RF_RD_DATA = 8'h7E; RF_RD_DATA_VLD = 1'b1;
    tick();
    RF_RD_DATA_VLD = 1'b0; RF_RD_DATA = 8'h00;
    check("rd_txv_gap", TX_D_VLD, 0);
    tick();
    check("rd_txv", TX_D_VLD, 1);
    check("rd_txd", TX_P_DATA, 8'h7E);
    tick();
    check("rd_txv_off", TX_D_VLD, 0);
    tick();
    check("rd_idle_txv", TX_D_VLD, 0);

    // ALU with operands, bench emulates transmitter busy after acceptance
    send_byte(8'hCC); send_byte(8'h10);
    check("opa_wr",   RF_WR_EN, 1);
    check("opa_addr", RF_ADDR, 0);
    check("opa_data", RF_WR_DATA, 8'h10);
    tick();
    send_byte(8'h20);
    check("opb_wr",   RF_WR_EN, 1);
    check("opb_addr", RF_ADDR, 1);
    check("opb_data", RF_WR_DATA, 8'h20);
    tick();
    send_byte(8'h01);
    check("fun_en",  ALU_EN, 1);
    check("fun_val", ALU_FUN, 1);
    check("fun_wr",  RF_WR_EN, 0);
    tick();
    check("fun_en_off", ALU_EN, 0);
    send_byte(8'h77);
    check("aw_err", CMD_ERR, 1);
    check_quiet("aw_drop");
    tick();
    check("aw_err_off", CMD_ERR, 0);
    ALU_OUT = 16'h0030; ALU_OUT_VLD = 1'b1;
    tick();
    ALU_OUT_VLD = 1'b0; ALU_OUT = 16'hFFFF;
    tick();
    check("alu_lo_v", TX_D_VLD, 1);
    check("alu_lo_d", TX_P_DATA, 8'h30);
    tick();
    TX_BUSY = 1'b1;
    check("alu_lo_off", TX_D_VLD, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("alu_gap", TX_D_VLD, 0);
    end
    TX_BUSY = 1'b0;
    tick();
    check("alu_hi_v", TX_D_VLD, 1);
    check("alu_hi_d", TX_P_DATA, 8'h00);
    tick();
    check("alu_hi_off", TX_D_VLD, 0);
    tick();

    // FUN-only command with TX_BUSY held for 10 cycles while a byte is offered
    send_byte(8'hDD); send_byte(8'h02);
    check("f2_en",  ALU_EN, 1);
    check("f2_fun", ALU_FUN, 2);
    ALU_OUT = 16'hA55A; ALU_OUT_VLD = 1'b1;
    tick();
    ALU_OUT_VLD = 1'b0;
    tick();
    check("f2_lo_v", TX_D_VLD, 1);
    check("f2_lo_d", TX_P_DATA, 8'h5A);
    TX_BUSY = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_v", TX_D_VLD, 1);
      check("hold_d", TX_P_DATA, 8'h5A);
    end
    TX_BUSY = 1'b0;
    tick();
    check("f2_lo_off", TX_D_VLD, 0);
    tick();
    check("f2_hi_v", TX_D_VLD, 1);
    check("f2_hi_d", TX_P_DATA, 8'hA5);
    tick();
    check("f2_hi_off", TX_D_VLD, 0);
    tick();

    // Unknown command in IDLE
    send_byte(8'h55);
    check("unk_err", CMD_ERR, 1);
    check_quiet("unk");
    tick();
    check("unk_err_off", CMD_ERR, 0);

    // Reset mid write aborts it; next byte is a command
    send_byte(8'hAA); send_byte(8'h05);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check_quiet("abort");
    check("abort_addr", RF_ADDR, 0);
    send_byte(8'h3C);
    check("abort_err", CMD_ERR, 1);
    check("abort_wr",  RF_WR_EN, 0);
    tick(); tick();

    check("cnt_wr",  wr_cnt, 3);
    check("cnt_rd",  rd_cnt, 1);
    check("cnt_alu", alu_cnt, 2);
    check("cnt_err", err_cnt, 3);
    check("overlap", overlap, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
